// File: rtl/riscv_pkg.sv
// Base RISC-V architectural constants shared across the core.
package riscv_pkg;

    localparam int unsigned MXLEN = 64;

endpackage

// File: rtl/riscv_privileged_pkg.sv
// Machine-mode trap types: sequencer states, interrupt cause codes and mtvec modes.
package riscv_privileged_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        TRAP     = 2'd1,
        MRET     = 2'd2,
        REDIRECT = 2'd3
    } trap_state_t;

    localparam logic [3:0] IRQ_CODE_MSI = 4'd3;
    localparam logic [3:0] IRQ_CODE_MTI = 4'd7;
    localparam logic [3:0] IRQ_CODE_MEI = 4'd11;

    // Bit positions inside irq_i / mie_i.
    localparam int unsigned IRQ_BIT_MSI = 0;
    localparam int unsigned IRQ_BIT_MTI = 1;
    localparam int unsigned IRQ_BIT_MEI = 2;

    typedef enum logic [1:0] {
        MTVEC_DIRECT   = 2'd0,
        MTVEC_VECTORED = 2'd1,
        MTVEC_RSVD2    = 2'd2,
        MTVEC_RSVD3    = 2'd3
    } mtvec_mode_t;

endpackage

// File: rtl/interrupt_priority_encoder.sv
// Picks the highest-priority enabled machine interrupt: MEI, then MSI, then MTI.
module interrupt_priority_encoder
    import riscv_privileged_pkg::*;
(
    input  logic [2:0] i_pending,
    output logic       o_taken,
    output logic [3:0] o_code
);

    always_comb begin
        o_taken = 1'b0;
        o_code  = '0;
        if (i_pending[IRQ_BIT_MEI]) begin
            o_taken = 1'b1;
            o_code  = IRQ_CODE_MEI;
        end else if (i_pending[IRQ_BIT_MSI]) begin
            o_taken = 1'b1;
            o_code  = IRQ_CODE_MSI;
        end else if (i_pending[IRQ_BIT_MTI]) begin
            o_taken = 1'b1;
            o_code  = IRQ_CODE_MTI;
        end
    end

endmodule

// File: rtl/trap_sequencer.sv
// Machine-mode trap entry / MRET sequencer: latches the request, strobes the
// trap CSRs and mstatus for one cycle, then holds a fetch redirect until accepted.
module trap_sequencer
    import riscv_pkg::*;
    import riscv_privileged_pkg::*;
(
    input  logic             clock_i,
    input  logic             reset_ni,
    input  logic             exc_valid_i,
    input  logic [4:0]       exc_cause_i,
    input  logic [MXLEN-1:0] exc_tval_i,
    input  logic [MXLEN-1:0] pc_i,
    input  logic             mret_i,
    output logic             exc_ready_o,
    input  logic [2:0]       irq_i,
    input  logic [2:0]       mie_i,
    input  logic             mstatus_mie_i,
    input  logic             mstatus_mpie_i,
    input  logic [MXLEN-1:0] mtvec_i,
    input  logic [MXLEN-1:0] mepc_i,
    output logic             trap_we_o,
    output logic [MXLEN-1:0] mepc_o,
    output logic [MXLEN-1:0] mcause_o,
    output logic [MXLEN-1:0] mtval_o,
    output logic             mstatus_we_o,
    output logic             mstatus_mie_o,
    output logic             mstatus_mpie_o,
    output logic             redirect_valid_o,
    input  logic             redirect_ready_i,
    output logic [MXLEN-1:0] redirect_pc_o
);

    localparam logic [MXLEN-1:0] ALIGN_MASK = {{(MXLEN-2){1'b1}}, 2'b00};

    trap_state_t      r_state;
    trap_state_t      w_state_next;
    logic [MXLEN-1:0] r_pc;
    logic [MXLEN-1:0] r_cause;
    logic [MXLEN-1:0] r_tval;
    logic [MXLEN-1:0] r_redirect_pc;

    logic [2:0]       w_irq_pending;
    logic             w_irq_taken;
    logic [3:0]       w_irq_code;
    logic             w_idle;
    logic             w_accept_exc;
    logic             w_accept_mret;
    logic             w_accept_irq;
    mtvec_mode_t      w_mtvec_mode;
    logic [MXLEN-1:0] w_vector_off;
    logic [MXLEN-1:0] w_trap_target;
    logic [MXLEN-1:0] w_mret_target;

    assign w_irq_pending = irq_i & mie_i;

    interrupt_priority_encoder u_irq_enc (
        .i_pending (w_irq_pending),
        .o_taken   (w_irq_taken),
        .o_code    (w_irq_code)
    );

    // Fixed priority: exception beats MRET beats interrupt; losers are dropped.
    assign w_idle        = (r_state == IDLE);
    assign w_accept_exc  = w_idle && exc_valid_i;
    assign w_accept_mret = w_idle && !exc_valid_i && mret_i;
    assign w_accept_irq  = w_idle && !exc_valid_i && !mret_i && mstatus_mie_i && w_irq_taken;

    // Only interrupts are vectored; reserved modes fall back to direct.
    assign w_mtvec_mode  = mtvec_mode_t'(mtvec_i[1:0]);
    assign w_vector_off  = {{(MXLEN-6){1'b0}}, r_cause[3:0], 2'b00};
    assign w_trap_target = (mtvec_i & ALIGN_MASK)
                         + (((w_mtvec_mode == MTVEC_VECTORED) && r_cause[MXLEN-1]) ? w_vector_off : '0);
    assign w_mret_target = mepc_i & ALIGN_MASK;

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        trap_we_o        = 1'b0;
        mstatus_we_o     = 1'b0;
        mstatus_mie_o    = 1'b0;
        mstatus_mpie_o   = 1'b0;
        redirect_valid_o = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_accept_exc || w_accept_irq) begin
                    w_state_next = TRAP;
                end else if (w_accept_mret) begin
                    w_state_next = MRET;
                end
            end
            TRAP: begin
                trap_we_o      = 1'b1;
                mstatus_we_o   = 1'b1;
                mstatus_mie_o  = 1'b0;
                mstatus_mpie_o = mstatus_mie_i;
                w_state_next   = REDIRECT;
            end
            MRET: begin
                mstatus_we_o   = 1'b1;
                mstatus_mie_o  = mstatus_mpie_i;
                mstatus_mpie_o = 1'b1;
                w_state_next   = REDIRECT;
            end
            REDIRECT: begin
                redirect_valid_o = 1'b1;
                if (redirect_ready_i) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_pc          <= '0;
            r_cause       <= '0;
            r_tval        <= '0;
            r_redirect_pc <= '0;
        end else begin
            if (w_accept_exc) begin
                r_pc    <= pc_i;
                r_cause <= {{(MXLEN-5){1'b0}}, exc_cause_i};
                r_tval  <= exc_tval_i;
            end else if (w_accept_irq) begin
                r_pc    <= pc_i;
                r_cause <= {1'b1, {(MXLEN-5){1'b0}}, w_irq_code};
                r_tval  <= '0;
            end
            // Target is captured once so it stays stable under redirect backpressure.
            if (r_state == TRAP) begin
                r_redirect_pc <= w_trap_target;
            end else if (r_state == MRET) begin
                r_redirect_pc <= w_mret_target;
            end
        end
    end

    assign exc_ready_o   = w_idle;
    assign mepc_o        = r_pc;
    assign mcause_o      = r_cause;
    assign mtval_o       = r_tval;
    assign redirect_pc_o = r_redirect_pc;

endmodule

// File: tb/tb_trap_sequencer.sv
// Scoreboard bench for trap_sequencer: directed scenarios plus randomized traffic
// checked against a request-level reference model.
module tb_trap_sequencer;

    logic        clock_i;
    logic        reset_ni;
    logic        exc_valid_i;
    logic [4:0]  exc_cause_i;
    logic [63:0] exc_tval_i;
    logic [63:0] pc_i;
    logic        mret_i;
    logic        exc_ready_o;
    logic [2:0]  irq_i;
    logic [2:0]  mie_i;
    logic        mstatus_mie_i;
    logic        mstatus_mpie_i;
    logic [63:0] mtvec_i;
    logic [63:0] mepc_i;
    logic        trap_we_o;
    logic [63:0] mepc_o;
    logic [63:0] mcause_o;
    logic [63:0] mtval_o;
    logic        mstatus_we_o;
    logic        mstatus_mie_o;
    logic        mstatus_mpie_o;
    logic        redirect_valid_o;
    logic        redirect_ready_i;
    logic [63:0] redirect_pc_o;

    trap_sequencer dut (
        .clock_i          (clock_i),
        .reset_ni         (reset_ni),
        .exc_valid_i      (exc_valid_i),
        .exc_cause_i      (exc_cause_i),
        .exc_tval_i       (exc_tval_i),
        .pc_i             (pc_i),
        .mret_i           (mret_i),
        .exc_ready_o      (exc_ready_o),
        .irq_i            (irq_i),
        .mie_i            (mie_i),
        .mstatus_mie_i    (mstatus_mie_i),
        .mstatus_mpie_i   (mstatus_mpie_i),
        .mtvec_i          (mtvec_i),
        .mepc_i           (mepc_i),
        .trap_we_o        (trap_we_o),
        .mepc_o           (mepc_o),
        .mcause_o         (mcause_o),
        .mtval_o          (mtval_o),
        .mstatus_we_o     (mstatus_we_o),
        .mstatus_mie_o    (mstatus_mie_o),
        .mstatus_mpie_o   (mstatus_mpie_o),
        .redirect_valid_o (redirect_valid_o),
        .redirect_ready_i (redirect_ready_i),
        .redirect_pc_o    (redirect_pc_o)
    );

    initial clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

    typedef struct {
        bit          is_trap;
        logic [63:0] mepc;
        logic [63:0] mcause;
        logic [63:0] mtval;
        logic        mie;
        logic        mpie;
    } exp_t;

    exp_t        csr_q[$];
    logic [63:0] rd_q[$];
    bit          m_idle = 1'b1;
    int          m_wait = 0;
    int          n_cmp  = 0;
    int          n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Reference rules, written from the architectural description.
    function automatic logic [63:0] irq_cause(input logic [2:0] p);
        int code;
        if (p[2])      code = 11;
        else if (p[0]) code = 3;
        else           code = 7;
        return (64'd1 << 63) | 64'(code);
    endfunction

    function automatic logic [63:0] trap_target(input logic [63:0] tvec, input logic [63:0] cause);
        logic [63:0] base;
        base = (tvec >> 2) << 2;
        if (tvec[1:0] == 2'd1 && cause[63]) base = base + 64'(cause[3:0]) * 64'd4;
        return base;
    endfunction

    function automatic exp_t mk_trap(input logic [63:0] pc, input logic [63:0] cause, input logic [63:0] tval);
        exp_t e;
        e.is_trap = 1'b1;
        e.mepc    = pc;
        e.mcause  = cause;
        e.mtval   = tval;
        e.mie     = 1'b0;
        e.mpie    = mstatus_mie_i;
        return e;
    endfunction

    function automatic exp_t mk_mret();
        exp_t e;
        e.is_trap = 1'b0;
        e.mepc    = '0;
        e.mcause  = '0;
        e.mtval   = '0;
        e.mie     = mstatus_mpie_i;
        e.mpie    = 1'b1;
        return e;
    endfunction

    // Reference model: one request in flight, two busy cycles, then wait for the handshake.
    initial begin
        logic [63:0] cause;
        forever begin
            @(posedge clock_i);
            if (!reset_ni) begin
                m_idle = 1'b1;
                m_wait = 0;
                csr_q.delete();
                rd_q.delete();
            end else if (m_idle) begin
                if (exc_valid_i) begin
                    cause = 64'(exc_cause_i);
                    csr_q.push_back(mk_trap(pc_i, cause, exc_tval_i));
                    rd_q.push_back(trap_target(mtvec_i, cause));
                    m_idle = 1'b0;
                    m_wait = 1;
                end else if (mret_i) begin
                    csr_q.push_back(mk_mret());
                    rd_q.push_back((mepc_i >> 2) << 2);
                    m_idle = 1'b0;
                    m_wait = 1;
                end else if (mstatus_mie_i && (irq_i & mie_i) != 3'b000) begin
                    cause = irq_cause(irq_i & mie_i);
                    csr_q.push_back(mk_trap(pc_i, cause, 64'd0));
                    rd_q.push_back(trap_target(mtvec_i, cause));
                    m_idle = 1'b0;
                    m_wait = 1;
                end
            end else if (m_wait > 0) begin
                m_wait--;
            end else if (redirect_ready_i) begin
                m_idle = 1'b1;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT strobes or presents a redirect.
    initial begin
        exp_t        e;
        bit          hold;
        logic [63:0] hold_pc;
        hold = 1'b0;
        hold_pc = '0;
        forever begin
            @(negedge clock_i);
            if (!reset_ni) begin
                hold = 1'b0;
            end else begin
                chk1("exc_ready", exc_ready_o, m_idle);
                if (trap_we_o || mstatus_we_o) begin
                    if (csr_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL strobe: got trap_we=%b mstatus_we=%b, expected no strobe", trap_we_o, mstatus_we_o);
                    end else begin
                        e = csr_q.pop_front();
                        chk1("trap_we", trap_we_o, e.is_trap);
                        chk1("mstatus_we", mstatus_we_o, 1'b1);
                        chk1("mstatus_mie", mstatus_mie_o, e.mie);
                        chk1("mstatus_mpie", mstatus_mpie_o, e.mpie);
                        if (e.is_trap) begin
                            chk("mepc", mepc_o, e.mepc);
                            chk("mcause", mcause_o, e.mcause);
                            chk("mtval", mtval_o, e.mtval);
                        end
                    end
                end
                if (redirect_valid_o) begin
                    if (rd_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL redirect: got valid with pc %h, expected no redirect", redirect_pc_o);
                    end else begin
                        chk("redirect_pc", redirect_pc_o, rd_q[0]);
                        if (redirect_ready_i) void'(rd_q.pop_front());
                    end
                    if (hold) chk("redirect_hold", redirect_pc_o, hold_pc);
                    hold    = !redirect_ready_i;
                    hold_pc = redirect_pc_o;
                end else begin
                    if (hold) chk1("redirect_held_valid", redirect_valid_o, 1'b1);
                    hold = 1'b0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got still running, expected finished");
        $fatal(1, "timeout");
    end

    task automatic cycle();
        @(posedge clock_i);
        #2;
    endtask

    task automatic clear_req();
        exc_valid_i = 1'b0;
        mret_i      = 1'b0;
        irq_i       = 3'b000;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (exc_ready_o !== 1'b1 && n < 40) begin
            cycle();
            n++;
        end
        chk1("wait_idle", exc_ready_o, 1'b1);
    endtask

    initial begin
        reset_ni = 1'b0;
        clear_req();
        exc_cause_i = '0;
        exc_tval_i = '0;
        pc_i = '0;
        mie_i = '0;
        mstatus_mie_i = 1'b0;
        mstatus_mpie_i = 1'b0;
        mtvec_i = '0;
        mepc_i = '0;
        redirect_ready_i = 1'b1;
        repeat (3) @(posedge clock_i);
        @(negedge clock_i);
        chk1("rst_trap_we", trap_we_o, 1'b0);
        chk1("rst_redirect_valid", redirect_valid_o, 1'b0);
        chk("rst_mepc", mepc_o, 64'd0);
        chk("rst_redirect_pc", redirect_pc_o, 64'd0);
        cycle();
        reset_ni = 1'b1;
        @(negedge clock_i);
        chk1("rst_ready", exc_ready_o, 1'b1);

        // Exception, vectored mtvec but taken direct.
        cycle();
        mtvec_i = 64'h8000_0001;
        mstatus_mie_i = 1'b1;
        cycle();
        exc_valid_i = 1'b1;
        exc_cause_i = 5'd2;
        pc_i = 64'h8000_0010;
        exc_tval_i = 64'hDEAD;
        @(negedge clock_i);
        chk1("exc_accept_ready", exc_ready_o, 1'b1);
        cycle();
        clear_req();
        @(negedge clock_i);
        chk1("exc_trap_we", trap_we_o, 1'b1);
        chk("exc_mepc", mepc_o, 64'h8000_0010);
        chk("exc_mcause", mcause_o, 64'd2);
        chk("exc_mtval", mtval_o, 64'hDEAD);
        chk1("exc_mie", mstatus_mie_o, 1'b0);
        chk1("exc_mpie", mstatus_mpie_o, 1'b1);
        cycle();
        @(negedge clock_i);
        chk1("exc_redirect_valid", redirect_valid_o, 1'b1);
        chk("exc_redirect_pc", redirect_pc_o, 64'h8000_0000);
        cycle();
        @(negedge clock_i);
        chk1("exc_ready_back", exc_ready_o, 1'b1);

        // Vectored interrupt: MEI wins.
        cycle();
        pc_i = 64'h8000_0100;
        irq_i = 3'b111;
        mie_i = 3'b101;
        cycle();
        clear_req();
        @(negedge clock_i);
        chk1("irq_trap_we", trap_we_o, 1'b1);
        chk("irq_mcause", mcause_o, 64'h8000_0000_0000_000B);
        chk("irq_mtval", mtval_o, 64'd0);
        chk("irq_mepc", mepc_o, 64'h8000_0100);
        cycle();
        @(negedge clock_i);
        chk("irq_redirect_pc", redirect_pc_o, 64'h8000_002C);
        cycle();

        // Global MIE clear masks interrupts.
        mstatus_mie_i = 1'b0;
        cycle();
        irq_i = 3'b010;
        mie_i = 3'b010;
        repeat (10) begin
            @(negedge clock_i);
            chk1("mask_ready", exc_ready_o, 1'b1);
            chk1("mask_strobe", trap_we_o | mstatus_we_o, 1'b0);
            cycle();
        end
        clear_req();
        mstatus_mie_i = 1'b1;

        // Exception and MRET together: only the trap runs.
        cycle();
        exc_valid_i = 1'b1;
        mret_i = 1'b1;
        exc_cause_i = 5'd5;
        pc_i = 64'h8000_0040;
        exc_tval_i = 64'h1234;
        cycle();
        clear_req();
        @(negedge clock_i);
        chk1("simul_trap_we", trap_we_o, 1'b1);
        chk1("simul_mie", mstatus_mie_o, 1'b0);
        wait_idle();
        mepc_i = 64'h8000_0013;
        mstatus_mpie_i = 1'b1;
        cycle();
        mret_i = 1'b1;
        cycle();
        clear_req();
        @(negedge clock_i);
        chk1("mret_we", mstatus_we_o, 1'b1);
        chk1("mret_trap_we", trap_we_o, 1'b0);
        chk1("mret_mie", mstatus_mie_o, 1'b1);
        chk1("mret_mpie", mstatus_mpie_o, 1'b1);
        cycle();
        @(negedge clock_i);
        chk("mret_redirect_pc", redirect_pc_o, 64'h8000_0010);
        wait_idle();

        // Backpressure, requests ignored while busy.
        redirect_ready_i = 1'b0;
        exc_valid_i = 1'b1;
        exc_cause_i = 5'd7;
        pc_i = 64'h8000_0200;
        exc_tval_i = 64'd0;
        cycle();
        clear_req();
        cycle();
        exc_valid_i = 1'b1;
        exc_cause_i = 5'd1;
        repeat (5) begin
            @(negedge clock_i);
            chk1("bp_valid", redirect_valid_o, 1'b1);
            chk("bp_pc", redirect_pc_o, 64'h8000_0000);
            chk1("bp_strobe", trap_we_o | mstatus_we_o, 1'b0);
            cycle();
        end
        clear_req();
        redirect_ready_i = 1'b1;
        cycle();
        @(negedge clock_i);
        chk1("bp_ready_back", exc_ready_o, 1'b1);

        // Reset while in REDIRECT.
        cycle();
        redirect_ready_i = 1'b0;
        exc_valid_i = 1'b1;
        exc_cause_i = 5'd4;
        cycle();
        clear_req();
        cycle();
        @(negedge clock_i);
        chk1("rr_valid_before", redirect_valid_o, 1'b1);
        #1 reset_ni = 1'b0;
        #1;
        chk1("rr_valid", redirect_valid_o, 1'b0);
        chk1("rr_trap_we", trap_we_o, 1'b0);
        chk1("rr_mstatus_we", mstatus_we_o, 1'b0);
        chk("rr_redirect_pc", redirect_pc_o, 64'd0);
        chk("rr_mepc", mepc_o, 64'd0);
        chk("rr_mcause", mcause_o, 64'd0);
        chk("rr_mtval", mtval_o, 64'd0);
        cycle();
        cycle();
        reset_ni = 1'b1;
        redirect_ready_i = 1'b1;
        @(negedge clock_i);
        chk1("rr_ready", exc_ready_o, 1'b1);

        // Randomized traffic; CSR inputs only change while idle with no request.
        for (int i = 0; i < 600; i++) begin
            cycle();
            if (m_idle && $urandom_range(0, 5) == 0) begin
                clear_req();
                mtvec_i        = {$urandom, $urandom};
                mepc_i         = {$urandom, $urandom};
                mstatus_mie_i  = 1'($urandom);
                mstatus_mpie_i = 1'($urandom);
            end else begin
                exc_valid_i = ($urandom_range(0, 5) == 0);
                mret_i      = ($urandom_range(0, 7) == 0);
                exc_cause_i = 5'($urandom);
                pc_i        = {$urandom, $urandom};
                exc_tval_i  = {$urandom, $urandom};
                irq_i       = 3'($urandom);
                mie_i       = 3'($urandom);
            end
            redirect_ready_i = ($urandom_range(0, 2) != 0);
            if (i == 300) reset_ni = 1'b0;
            if (i == 302) reset_ni = 1'b1;
        end

        cycle();
        clear_req();
        redirect_ready_i = 1'b1;
        wait_idle();
        repeat (3) cycle();
        chk("csr_q_left", 64'(csr_q.size()), 64'd0);
        chk("rd_q_left", 64'(rd_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/trap_sequencer.md
TRAP_SEQUENCER -- requirements
Module: trap_sequencer

Interface
REQ-001 Parameters: none; all data widths SHALL be MXLEN = 64, taken from riscv_pkg.
REQ-002 clock_i  in  1  clock; all state changes on the rising edge.
REQ-003 reset_ni  in  1  reset, asynchronous, active-low.
REQ-004 exc_valid_i  in  1  synchronous exception request from the core.
REQ-005 exc_cause_i  in  5  exception code (0..31).
REQ-006 exc_tval_i  in  64  trap value for the exception.
REQ-007 pc_i  in  64  PC of the faulting instruction, or of the next instruction for interrupts.
REQ-008 mret_i  in  1  MRET request.
REQ-009 exc_ready_o  out  1  sequencer idle; requests are accepted only while this is high.
REQ-010 irq_i  in  3  pending interrupts: [2] MEI, [1] MTI, [0] MSI.
REQ-011 mie_i  in  3  interrupt enables, same bit order as irq_i.
REQ-012 mstatus_mie_i, mstatus_mpie_i  in  1 each  current mstatus.MIE and mstatus.MPIE.
REQ-013 mtvec_i  in  64  trap vector CSR: base in [63:2], mode in [1:0].
REQ-014 mepc_i  in  64  current mepc CSR value.
REQ-015 trap_we_o  out  1  one-cycle write strobe for mepc, mcause and mtval.
REQ-016 mepc_o, mcause_o, mtval_o  out  64 each  CSR write data.
REQ-017 mstatus_we_o, mstatus_mie_o, mstatus_mpie_o  out  1 each  mstatus.MIE/MPIE write strobe and data.
REQ-018 redirect_valid_o / redirect_ready_i  out / in  1 each  fetch redirect handshake.
REQ-019 redirect_pc_o  out  64  redirect target PC.

Function
REQ-020 FSM states SHALL be IDLE, TRAP, MRET and REDIRECT; exc_ready_o SHALL be high only in IDLE.
REQ-021 In IDLE, request priority SHALL be: exc_valid_i, then mret_i, then interrupt.
  - Lower-priority requests arriving in the same cycle are dropped.
  - Requests arriving in any state other than IDLE are ignored.
REQ-022 An interrupt SHALL be taken in IDLE only when mstatus_mie_i is high and |(irq_i & mie_i) is true.
  - Interrupt priority: MEI (code 11), then MSI (code 3), then MTI (code 7).
REQ-023 On acceptance, the following SHALL be latched and the FSM SHALL move to TRAP (or MRET for an MRET request):
  - pc_i;
  - mcause: {1'b0, 58'b0, exc_cause_i} for an exception, or {1'b1, 59'b0, code} for an interrupt;
  - mtval: exc_tval_i for an exception, 0 for an interrupt.
REQ-024 TRAP SHALL last exactly one cycle and then go to REDIRECT, asserting:
  - trap_we_o with the latched values;
  - mstatus_we_o with MIE = 0 and MPIE = mstatus_mie_i.
REQ-025 MRET SHALL last exactly one cycle, then go to REDIRECT with target {mepc_i[63:2], 2'b00}, asserting mstatus_we_o with MIE = mstatus_mpie_i and MPIE = 1.
REQ-026 Trap target SHALL be {base, 2'b00}, plus (code << 2) only when mode = 1 and the trap is an interrupt; modes 2 and 3 SHALL be treated as direct.
REQ-027 REDIRECT SHALL hold redirect_valid_o high and redirect_pc_o stable until redirect_ready_i is high, then return to IDLE in the next cycle.
REQ-028 Latency: acceptance in cycle N, CSR strobe in N+1, redirect_valid_o in N+2; with ready already high, exc_ready_o returns in N+3.
REQ-029 Every strobe (trap_we_o, mstatus_we_o) SHALL be high for at most one cycle per accepted request.

Reset
REQ-030 Reset SHALL force state IDLE, all latched registers to 0, all outputs to 0, and exc_ready_o to 1 immediately after reset release.
REQ-031 Reset mid-operation SHALL abandon the sequence with no further strobe or redirect.

Structure
REQ-032 riscv_privileged_pkg SHALL hold trap_state_t, the interrupt code constants (MEI = 11, MSI = 3, MTI = 7) and the mtvec mode enum.
REQ-033 A combinational sub-module, interrupt_priority_encoder, SHALL produce the taken flag and the 4-bit code from irq_i & mie_i.

Verification
REQ-034 Exception: exc_cause_i = 2, pc_i = 0x8000_0010, tval = 0xDEAD, mtvec = 0x8000_0001 -> in N+1, mepc_o = 0x8000_0010, mcause_o = 2, mtval_o = 0xDEAD, MIE = 0; redirect_pc_o = 0x8000_0000.
REQ-035 Vectored interrupt: irq_i = 3'b111, mie_i = 3'b101, MIE = 1, mtvec = 0x8000_0001 -> mcause_o = 0x8000_0000_0000_000B, redirect_pc_o = 0x8000_002C.
REQ-036 Masking: irq_i = 3'b010, mie_i = 3'b010, MIE = 0 -> no strobe and exc_ready_o stays high for 10 cycles.
REQ-037 Simultaneous requests: exc_valid_i with mret_i -> only the trap sequence occurs; later MRET with mepc = 0x8000_0013, MPIE = 1 -> MIE = 1, redirect_pc_o = 0x8000_0010.
REQ-038 Backpressure: redirect_ready_i low for 5 cycles -> redirect_valid_o and redirect_pc_o held stable and a new exc_valid_i is ignored; reset asserted in REDIRECT -> all outputs 0.
